// File: rtl/count_mon_pkg.sv
// Shared constants for the counter sequence monitor: default widths and FSM state encodings.
package count_mon_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ARM   = 2'd0;
    localparam state_t TRACK = 2'd1;
    localparam state_t FAULT = 2'd2;

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of rolling over.
module sat_counter
    import count_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that the upstream counter advances by +1 (or wraps MAX->0) every cycle and emits
// registered wrap/match pulses, a sticky sequence error and a saturating wrap tally.
module count_seq_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter bit ALLOW_HOLD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] match_val,
    input  logic             clear,
    output logic             wrap_pulse,
    output logic             match_pulse,
    output logic             seq_error,
    output logic [CNT_W-1:0] wrap_count,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] nxt;
    logic             from_arm;
    logic             step_ok;
    logic             wrap_ok;
    logic             hold_seen;
    logic             accept;
    logic             match_hit;
    logic             tally_inc;

    always_comb begin
        nxt       = prev + 1'b1;
        wrap_ok   = (prev == MAXV) && (q_in == '0);
        step_ok   = (prev != MAXV) && (q_in == nxt);
        hold_seen = (q_in == prev);
        accept    = step_ok || wrap_ok || (hold_seen && ALLOW_HOLD);
        // A held matching value pulses only on the first TRACK cycle after ARM captured it.
        match_hit = accept && (q_in == match_val) && (!hold_seen || from_arm);
        tally_inc = (state == TRACK) && !clear && wrap_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARM;
            prev        <= '0;
            from_arm    <= 1'b0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            from_arm    <= (state == ARM);
            if (state == ARM) begin
                prev <= q_in;
            end
            if (clear) begin
                state     <= ARM;
                seq_error <= 1'b0;
            end else begin
                case (state)
                    ARM: state <= TRACK;
                    TRACK: begin
                        if (!accept) begin
                            seq_error <= 1'b1;
                            state     <= FAULT;
                        end else begin
                            prev        <= q_in;
                            wrap_pulse  <= wrap_ok;
                            match_pulse <= match_hit;
                        end
                    end
                    FAULT: state <= FAULT;
                    default: state <= ARM;
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_tally (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .inc  (tally_inc),
        .count(wrap_count)
    );

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench: three monitor variants (default, hold-allowed, 2-bit tally) share one stimulus stream.
module tb_count_seq_monitor;
    import count_mon_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] q_in;
    logic [3:0] match_val;
    logic       clear;

    logic       wp_d, mp_d, err_d, wp_h, mp_h, err_h, wp_s, mp_s, err_s;
    logic [7:0] cnt_d, cnt_h;
    logic [1:0] cnt_s;
    logic [1:0] st_d, st_h, st_s;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [1:0]  st;
        logic [3:0]  prev;
        logic        was_arm;
        logic        wp;
        logic        mp;
        logic        err;
        int unsigned cnt;
    } mdl_t;

    typedef struct {
        logic       wp;
        logic       mp;
        logic       err;
        logic [7:0] cnt;
        logic [1:0] st;
    } exp_t;

    mdl_t m_d, m_h, m_s;
    exp_t qd[$], qh[$], qs[$];

    always #5 clk = ~clk;

    count_seq_monitor u_def (
        .clk(clk), .reset(reset), .q_in(q_in), .match_val(match_val), .clear(clear),
        .wrap_pulse(wp_d), .match_pulse(mp_d), .seq_error(err_d), .wrap_count(cnt_d), .state(st_d)
    );

    count_seq_monitor #(.ALLOW_HOLD(1'b1)) u_hold (
        .clk(clk), .reset(reset), .q_in(q_in), .match_val(match_val), .clear(clear),
        .wrap_pulse(wp_h), .match_pulse(mp_h), .seq_error(err_h), .wrap_count(cnt_h), .state(st_h)
    );

    count_seq_monitor #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .q_in(q_in), .match_val(match_val), .clear(clear),
        .wrap_pulse(wp_s), .match_pulse(mp_s), .seq_error(err_s), .wrap_count(cnt_s), .state(st_s)
    );

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = ARM; m.prev = '0; m.was_arm = 1'b0;
        m.wp = 1'b0; m.mp = 1'b0; m.err = 1'b0; m.cnt = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [3:0] q, logic [3:0] mv, logic clr,
                                   bit ah, int unsigned cmax);
        mdl_t n;
        logic [3:0] nx;
        n = m;
        n.wp = 1'b0;
        n.mp = 1'b0;
        n.was_arm = (m.st == ARM);
        nx = m.prev + 4'd1;
        if (m.st == ARM) n.prev = q;
        if (clr) begin
            n.st = ARM; n.err = 1'b0; n.cnt = 0;
        end else if (m.st == ARM) begin
            n.st = TRACK;
        end else if (m.st == TRACK) begin
            if (q == nx) begin
                n.prev = q;
                n.mp = (q == mv);
                if (m.prev == 4'hF) begin
                    n.wp = 1'b1;
                    if (n.cnt < cmax) n.cnt = n.cnt + 1;
                end
            end else if ((q == m.prev) && ah) begin
                n.mp = (q == mv) && m.was_arm;
            end else begin
                n.err = 1'b1;
                n.st = FAULT;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.wp = m.wp; e.mp = m.mp; e.err = m.err; e.cnt = 8'(m.cnt); e.st = m.st;
        return e;
    endfunction

    task automatic step(input logic [3:0] q, input logic [3:0] mv, input logic clr);
        q_in = q;
        match_val = mv;
        clear = clr;
        @(posedge clk);
        m_d = mstep(m_d, q, mv, clr, 1'b0, 255);
        m_h = mstep(m_h, q, mv, clr, 1'b1, 255);
        m_s = mstep(m_s, q, mv, clr, 1'b0, 3);
        qd.push_back(to_exp(m_d));
        qh.push_back(to_exp(m_h));
        qs.push_back(to_exp(m_s));
        #2;
    endtask

    task automatic cmp_inst(string nm, exp_t e, logic wp, logic mp, logic err,
                            logic [7:0] cnt, logic [1:0] st);
        chk({nm, ".wrap_pulse"}, 32'(wp), 32'(e.wp));
        chk({nm, ".match_pulse"}, 32'(mp), 32'(e.mp));
        chk({nm, ".seq_error"}, 32'(err), 32'(e.err));
        chk({nm, ".wrap_count"}, 32'(cnt), 32'(e.cnt));
        chk({nm, ".state"}, 32'(st), 32'(e.st));
    endtask

    // Monitor: whenever the stimulus side has queued a response, compare it half a cycle later.
    always @(negedge clk) begin
        if (qd.size() > 0) cmp_inst("def", qd.pop_front(), wp_d, mp_d, err_d, cnt_d, st_d);
        if (qh.size() > 0) cmp_inst("hold", qh.pop_front(), wp_h, mp_h, err_h, cnt_h, st_h);
        if (qs.size() > 0) cmp_inst("sat", qs.pop_front(), wp_s, mp_s, err_s, {6'd0, cnt_s}, st_s);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        q_in = '0;
        match_val = 4'd9;
        clear = 1'b0;
        m_d = mreset(); m_h = mreset(); m_s = mreset();
        #3;
        chk("reset.state", 32'(st_d), 32'(ARM));
        chk("reset.wrap_count", 32'(cnt_d), 32'd0);
        #9;
        reset = 1'b0;

        // Free-running counter, match on 9
        for (int i = 0; i < 40; i++) begin
            step(4'(i), 4'd9, 1'b0);
            if (i == 9)  chk("run.match_at_9", 32'(mp_d), 32'd1);
            if (i == 16) chk("run.first_wrap", 32'(wp_d), 32'd1);
            if (i == 16) chk("run.count_after_wrap1", 32'(cnt_d), 32'd1);
            if (i == 17) chk("run.wrap_one_cycle", 32'(wp_d), 32'd0);
        end
        chk("run.count_two_wraps", 32'(cnt_d), 32'd2);
        chk("run.no_error", 32'(err_d), 32'd0);

        step(4'd8, 4'd0, 1'b1);
        chk("clear1.state", 32'(st_d), 32'(ARM));
        chk("clear1.count", 32'(cnt_d), 32'd0);

        // Wrap and match coincide when match_val is 0
        for (int i = 0; i < 17; i++) step(4'(i), 4'd0, 1'b0);
        chk("wm.wrap", 32'(wp_d), 32'd1);
        chk("wm.match", 32'(mp_d), 32'd1);

        // Skip 5 -> 7, with 7 matching: only the error is flagged
        for (int i = 1; i <= 5; i++) step(4'(i), 4'd7, 1'b0);
        step(4'd7, 4'd7, 1'b0);
        chk("skip.error", 32'(err_d), 32'd1);
        chk("skip.state", 32'(st_d), 32'(FAULT));
        chk("skip.no_match", 32'(mp_d), 32'd0);
        for (int i = 8; i <= 16; i++) step(4'(i), 4'd9, 1'b0);
        chk("fault.no_wrap", 32'(wp_d), 32'd0);
        chk("fault.count_frozen", 32'(cnt_d), 32'd1);
        step(4'd1, 4'd9, 1'b1);
        chk("clear2.state", 32'(st_d), 32'(ARM));
        chk("clear2.error", 32'(err_d), 32'd0);
        chk("clear2.count", 32'(cnt_d), 32'd0);

        // Hold at 3 for three samples
        step(4'd0, 4'd3, 1'b0);
        step(4'd1, 4'd3, 1'b0);
        step(4'd2, 4'd3, 1'b0);
        step(4'd3, 4'd3, 1'b0);
        chk("hold.first3_match", 32'(mp_h), 32'd1);
        step(4'd3, 4'd3, 1'b0);
        chk("hold.def_error", 32'(err_d), 32'd1);
        chk("hold.allowed_no_error", 32'(err_h), 32'd0);
        chk("hold.no_repeat_match", 32'(mp_h), 32'd0);
        step(4'd3, 4'd3, 1'b0);
        step(4'd4, 4'd3, 1'b0);
        step(4'd5, 4'd3, 1'b0);
        step(4'd6, 4'd9, 1'b1);

        // Five laps: 2-bit tally saturates at 3
        for (int i = 0; i <= 80; i++) begin
            step(4'(i), 4'd9, 1'b0);
            if (i == 64) chk("sat.count_at_lap4", 32'(cnt_s), 32'd3);
        end
        chk("sat.wrap_still_pulses", 32'(wp_s), 32'd1);
        chk("sat.count_held", 32'(cnt_s), 32'd3);
        chk("sat.def_count5", 32'(cnt_d), 32'd5);

        // Reset between edges at q_in = 11
        for (int i = 1; i <= 11; i++) step(4'(i), 4'd9, 1'b0);
        #4;
        reset = 1'b1;
        #1;
        chk("midreset.count", 32'(cnt_d), 32'd0);
        chk("midreset.state", 32'(st_d), 32'(ARM));
        chk("midreset.error", 32'(err_d), 32'd0);
        m_d = mreset(); m_h = mreset(); m_s = mreset();
        #1;
        reset = 1'b0;
        step(4'd0, 4'd9, 1'b0);
        chk("restart.arm_no_error", 32'(err_d), 32'd0);
        chk("restart.to_track", 32'(st_d), 32'(TRACK));
        step(4'd1, 4'd9, 1'b0);
        step(4'd2, 4'd9, 1'b0);
        chk("restart.counting_ok", 32'(err_d), 32'd0);

        @(negedge clk);
        #1;
        chk("scoreboard.drained", 32'(qd.size() + qh.size() + qs.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_seq_monitor.md
# count_seq_monitor

Downstream checker/event stage for the 4-bit synchronous up-counter. It samples the counter's `q` bus every clock, checks that each step is a legal +1 increment (or a 15→0 wrap), and raises registered one-cycle event pulses. Its event outputs are wrap, programmable match and sequence error, and it keeps a saturating wrap tally. It sits on the same clock and reset as the counter and feeds status/interrupt logic or a bench scoreboard.

## Interface
- `WIDTH`, 4, width of the monitored count bus
- `CNT_W`, 8, width of the wrap tally
- `ALLOW_HOLD`, 0, when 1, an unchanged sample (`q_in == prev`) is legal; when 0, it is a sequence error
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `q_in`  in  WIDTH  count value from the upstream counter, sampled each rising edge
- `match_val`  in  WIDTH  compare value; quasi-static
- `clear`  in  1  synchronous; clears the tally and the sticky error, and returns the FSM to ARM
- `wrap_pulse`  out  1  one-cycle pulse on a legal max→0 step
- `match_pulse`  out  1  one-cycle pulse when an accepted sample equals `match_val`
- `seq_error`  out  1  sticky illegal-step flag
- `wrap_count`  out  CNT_W  number of legal wraps, saturating at 2^CNT_W−1
- `state`  out  2  FSM state, for debug

## Operation
- FSM states, encoded in the shared package:
  - ARM = 2'd0
  - TRACK = 2'd1
  - FAULT = 2'd2
- ARM
  - Captures `q_in` into `prev`.
  - Produces no pulses and no error check.
  - Moves to TRACK next cycle.
- TRACK, each cycle, with `nxt = prev + 1` computed mod 2^WIDTH:
  - `q_in == nxt`, `prev != MAX`: legal step. `prev <= q_in`.
  - `q_in == 0`, `prev == MAX`: legal wrap. `wrap_pulse <= 1`. `wrap_count` increments unless already saturated. `prev <= 0`.
  - `q_in == prev`: legal if ALLOW_HOLD=1 (no pulses). Otherwise illegal.
  - Any other value: illegal. `seq_error <= 1` and the FSM goes to FAULT. `prev` is not updated.
- `match_pulse <= 1` when a legal or held sample in TRACK equals `match_val`.
  - A held value that matches pulses only once. The pulse requires `q_in != prev`, or the previous cycle being ARM.
- FAULT
  - No further pulses or tally updates.
  - `seq_error` stays 1.
  - Exit only via `clear` or `reset`.
- `clear` has priority over all TRACK/FAULT actions in the same cycle.
  - It zeroes `wrap_count` and `seq_error`.
  - It suppresses pulses that cycle.
  - The FSM goes to ARM.
- Width rule: all comparisons are WIDTH-bit unsigned; MAX = 2^WIDTH−1.

## Timing
- Reset values: `wrap_pulse=0`, `match_pulse=0`, `seq_error=0`, `wrap_count=0`, `state=ARM`, `prev=0`.
- Reset is asynchronous on assertion. It is released synchronously with respect to usage: the first edge after deassertion is an ARM cycle.
- Latency: all outputs are registered. An event on the `q_in` sampled at edge N is visible after edge N, for exactly one cycle for pulses.
- Reset mid-operation: outputs clear immediately without waiting for a clock; any pending pulse is dropped.
- Simultaneous wrap and match (`match_val=0`, 15→0 step): both pulses are asserted in the same cycle.
- Wrap while the tally is saturated: `wrap_pulse` still asserts and `wrap_count` holds at 255.
- Illegal step coinciding with `q_in == match_val`: no match pulse; only the error is flagged.

## Structure
- Package `count_mon_pkg`:
  - state typedef/localparams ARM, TRACK, FAULT
  - default WIDTH/CNT_W constants
- One natural sub-module, `sat_counter`: a CNT_W saturating incrementer with sync clear, used for `wrap_count`.
- Everything else (step classifier, FSM, pulse registers) lives in the top module.

## Test plan
- Free-running counter, reset released at 12 ns, run 40 cycles.
  - `wrap_pulse` fires on each 15→0 step, exactly one cycle, one cycle after the sample.
  - `wrap_count` = 2 after 2 wraps.
  - `seq_error` stays 0.
- `match_val=4'd9`: `match_pulse` once per lap, one cycle after `q_in=9`. `match_val=0`: pulse coincides with `wrap_pulse`.
- Force `q_in` 5→7 (skip):
  - `seq_error` = 1 next cycle; state = FAULT.
  - Subsequent wraps produce no pulse and no tally change.
  - `clear` → state ARM, error 0, tally 0.
- Hold `q_in` at 3 for 3 cycles:
  - ALLOW_HOLD=0: error on the first repeat.
  - ALLOW_HOLD=1: no error, and `match_val=3` gives a single match pulse.
- CNT_W=2, run 5 laps: `wrap_count` saturates at 3 while `wrap_pulse` still fires each lap.
- Assert `reset` mid-lap (at `q_in=11`, between edges): all outputs 0 immediately. After release, the first sample is ARM (no error, even though `q_in` restarts at 0).
